// File: rtl/cobro_efectivo.sv
// cobro_efectivo: cash-payment stage; collects coins against a latched price, pays change, refunds on cancel.
// Ports: clk/reset (async, active-high); start, cancel, price, coin_valid, coin_code in;
//        credit, coin_rej, chg_valid, chg_code, busy, done, refunded out.
// Coin encoding 00=1, 01=5, 10=10, 11=25. Define COBRO_TIMEOUT_EN for auto-refund after TIMEOUT_CYC idle cycles.
module cobro_efectivo #(
  parameter int W = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         cancel,
  input  logic [W-1:0] price,
  input  logic         coin_valid,
  input  logic [1:0]   coin_code,
  output logic [W-1:0] credit,
  output logic         coin_rej,
  output logic         chg_valid,
  output logic [1:0]   chg_code,
  output logic         busy,
  output logic         done,
  output logic         refunded
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHANGE  = 3'd2;
  localparam logic [2:0] S_REFUND  = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  logic [2:0]   r_state;
  logic [W-1:0] r_price;
  logic [W-1:0] r_rem;
  logic [W:0]   w_val;
  logic [W:0]   w_sum;
  logic         w_ovf;
  logic [W-1:0] w_cred_nx;
  logic [1:0]   w_code;
  logic [W-1:0] w_cval;
  logic         w_to;

  assign w_val = coin_code == 2'b11 ? (W+1)'(25) :
                 coin_code == 2'b10 ? (W+1)'(10) :
                 coin_code == 2'b01 ? (W+1)'(5)  : (W+1)'(1);
  // one extra bit so an overflowing coin is detected rather than wrapped
  assign w_sum     = {1'b0, credit} + (coin_valid ? w_val : '0);
  assign w_ovf     = w_sum[W];
  assign w_cred_nx = w_ovf ? credit : w_sum[W-1:0];
  // greedy change: largest coin not exceeding the remainder
  assign w_code = r_rem >= W'(25) ? 2'b11 :
                  r_rem >= W'(10) ? 2'b10 :
                  r_rem >= W'(5)  ? 2'b01 : 2'b00;
  assign w_cval = w_code == 2'b11 ? W'(25) :
                  w_code == 2'b10 ? W'(10) :
                  w_code == 2'b01 ? W'(5)  : W'(1);
  assign busy = r_state != S_IDLE;

`ifdef COBRO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to;
  // held at zero outside COLLECT so every COLLECT entry starts a fresh count
  always_ff @(posedge clk or posedge reset)
    if (reset) r_to <= '0;
    else r_to <= (r_state != S_COLLECT || coin_valid) ? '0 : r_to + 1'b1;
  assign w_to = r_state == S_COLLECT && !coin_valid && r_to == TW'(TIMEOUT_CYC - 1);
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_price   <= '0;
      r_rem     <= '0;
      credit    <= '0;
      coin_rej  <= 1'b0;
      chg_valid <= 1'b0;
      chg_code  <= 2'b00;
      done      <= 1'b0;
      refunded  <= 1'b0;
    end else begin
      coin_rej  <= 1'b0;
      chg_valid <= 1'b0;
      chg_code  <= 2'b00;
      done      <= 1'b0;
      refunded  <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state <= S_COLLECT;
            r_price <= price;
            credit  <= '0;
          end
        S_COLLECT: begin
          coin_rej <= w_ovf;
          credit   <= w_cred_nx;
          // cancel and timeout win over payment; a coin in the same cycle is refunded too
          if (cancel || w_to) begin
            r_state <= S_REFUND;
            r_rem   <= w_cred_nx;
          end else if (w_cred_nx >= r_price) begin
            r_state <= S_CHANGE;
            r_rem   <= w_cred_nx - r_price;
          end
        end
        S_CHANGE, S_REFUND:
          if (r_rem != '0) begin
            chg_valid <= 1'b1;
            chg_code  <= w_code;
            r_rem     <= r_rem - w_cval;
          end else if (r_state == S_CHANGE) begin
            done    <= 1'b1;
            r_state <= S_FIN;
          end else begin
            refunded <= 1'b1;
            credit   <= '0;
            r_state  <= S_IDLE;
          end
        S_FIN: begin
          credit  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
